// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch and decode stages.
// Holds opcode constants, instruction field positions, the instr_t
// bundle and the fetch FSM state type.
// Config: IFETCH_HALT_DET_EN adds the HALT fetch state.
package isa_pkg;

    localparam int ISA_W  = 16;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int A_HI   = 11;
    localparam int A_LO   = 6;
    localparam int B_HI   = 5;
    localparam int B_LO   = 0;

    // ALU group
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    // IMM group
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    // MOV group
    localparam logic [3:0] OP_MOV  = 4'h7;
    // MEM group
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [3:0] opcode;
        logic [5:0] a;
        logic [5:0] b;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH
`ifdef IFETCH_HALT_DET_EN
        , ST_HALT
`endif
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs.
// Ports: clk/rst, flush (clears all entries), push/push_data,
// pop (ignored when empty), head (oldest entry), count (occupancy).
module ifetch_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 24,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle ROM, buffers
// words in a prefetch FIFO and hands them to the decoder (valid/ready).
// Ports: clk, rst, fetch_en, jump_en/jump_addr, imem_rd/imem_addr/
// imem_rdata, instr_out/instr_pc/instr_valid/instr_ready, halted.
// Config: IFETCH_HALT_DET_EN stops fetching on an OP_HALT word.
module ifetch_unit
    import isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              credit;
    logic              issue;
    logic              pop;
    logic              halt_det;

    // The in-flight word is credited so the FIFO can never overflow.
    assign credit = (count + CW'(inflight)) < CW'(FIFO_DEPTH);

`ifdef IFETCH_HALT_DET_EN
    assign halt_det = inflight
                   && (imem_rdata[OPC_HI:OPC_LO] == OP_HALT);
    assign halted   = (state == ST_HALT);
`else
    assign halt_det = 1'b0;
    assign halted   = 1'b0;
`endif

    // Suppressing the issue alongside a HALT response keeps PC at
    // HALT PC+1 without any rollback.
    assign issue = (state == ST_FETCH) && credit
                && !jump_en && !halt_det;

    assign imem_rd     = issue;
    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !jump_en;
    assign instr_out   = instr_valid ? head[INSTR_W-1:0] : '0;
    assign instr_pc    = instr_valid ? head[EW-1:INSTR_W] : '0;

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (fetch_en) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (halt_det)       state_next = fetch_state_t'(2'd2);
                else if (!fetch_en) state_next = ST_IDLE;
            end
`ifdef IFETCH_HALT_DET_EN
            ST_HALT: state_next = ST_HALT;
`endif
            default: state_next = ST_IDLE;
        endcase
        if (jump_en) begin
            state_next = fetch_en ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (jump_en) begin
                pc <= jump_addr;
            end else if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    // A response arriving in a jump cycle is lost to the flush.
    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_en),
        .push      (inflight),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule
